// File: rtl/sampler_ring.sv
// -----------------------------------------------------------------------------
// sampler_ring
//
// Multi-channel event sampler. Each differential discriminator channel is
// received, brought into the clk domain through a two-flop synchroniser and
// shifted one bit per cycle into a DEPTH-deep window per channel. A rising
// edge on trig_tresh, accepted while ARMED, freezes the window POST_TRIG
// shifts later. The trigger-cycle sample then sits at bit POST_TRIG, with
// older samples above it and newer samples below it. The frozen event is held
// until the readout block acknowledges it with event_saved. Trigger edges
// that arrive while the block cannot accept them are counted in a saturating
// counter.
//
// Optional feature (macro SAMPLER_TIMESTAMP_EN):
//   defined   - a free-running TS_W-bit cycle counter starts at 0 when reset
//               is released. Its value is latched into trig_ts on every
//               accepted trigger edge.
//   undefined - no counter is built and trig_ts is constant 0.
//
// Parameters:
//   N_CH      number of channels
//   DEPTH     samples kept per channel (>= 2)
//   POST_TRIG samples captured after the trigger sample (1 .. DEPTH-1)
//   TS_W      timestamp width
//
// Ports:
//   clk          sample clock; the only clock
//   aresetn      asynchronous active-low reset
//   Ch_A_P/N     differential channel inputs, one pair per channel
//   trig_tresh   threshold trigger, synchronous to clk; rising edges only
//   event_saved  readout acknowledge; sampled as a level, only in HOLD
//   evento       sample window per channel; bit 0 is the newest sample
//   event_ready  high while a frozen event is held
//   missed_trig  saturating count of rejected trigger edges
//   trig_ts      timestamp of the last accepted trigger
//
// Every output is driven directly by a flop. No input reaches an output
// through combinational logic.
// -----------------------------------------------------------------------------
module sampler_ring #(
    parameter int N_CH      = 16,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 32,
    parameter int TS_W      = 32
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic [N_CH-1:0]                  Ch_A_P,
    input  logic [N_CH-1:0]                  Ch_A_N,
    input  logic                             trig_tresh,
    input  logic                             event_saved,
    output logic [N_CH-1:0][DEPTH-1:0]       evento,
    output logic                             event_ready,
    output logic [15:0]                      missed_trig,
    output logic [TS_W-1:0]                  trig_ts
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // In FILL, cnt runs 0 .. FILL_LAST. The shift made while cnt == FILL_LAST
    // is the (DEPTH-POST_TRIG)-th shift and completes the fill.
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DEPTH - POST_TRIG - 1);
    localparam logic [CNT_W-1:0] POST_LEN  = CNT_W'(POST_TRIG);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Differential receivers.
    // A pair reads as 1 when the positive leg is high and the negative leg is
    // low. This is the behaviour of the IBUFDS input buffer for a valid pair.
    // -------------------------------------------------------------------------
    logic [N_CH-1:0] rx_data;

    assign rx_data = Ch_A_P & ~Ch_A_N;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                       state_q,       state_d;
    logic [CNT_W-1:0]             cnt_q,         cnt_d;
    logic [N_CH-1:0]              sync1_q,       sync1_d;
    logic [N_CH-1:0]              sync2_q,       sync2_d;   // s[c]
    logic                         trig_prev_q,   trig_prev_d;
    logic [N_CH-1:0][DEPTH-1:0]   evento_q,      evento_d;
    logic                         event_ready_q, event_ready_d;
    logic [15:0]                  missed_q,      missed_d;

`ifdef SAMPLER_TIMESTAMP_EN
    logic [TS_W-1:0]              ts_q,          ts_d;
    logic [TS_W-1:0]              trig_ts_q,     trig_ts_d;
`endif

    logic trig_edge;
    logic trig_reject;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first. Without the
        // defaults, any path that skips an assignment infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        evento_d      = evento_q;
        event_ready_d = event_ready_q;
        missed_d      = missed_q;
        trig_reject   = 1'b0;

        // The synchroniser and the trigger history run in every state.
        sync1_d     = rx_data;
        sync2_d     = sync1_q;
        trig_prev_d = trig_tresh;
        trig_edge   = trig_tresh & ~trig_prev_q;

`ifdef SAMPLER_TIMESTAMP_EN
        ts_d      = ts_q + TS_W'(1);
        trig_ts_d = trig_ts_q;
`endif

        // The window shifts in every state except HOLD. In the trigger cycle
        // the window takes in the trigger sample as bit 0. After POST_TRIG
        // more shifts, that sample sits at bit POST_TRIG.
        if (state_q != ST_HOLD) begin
            for (int c = 0; c < N_CH; c++) begin
                evento_d[c] = {evento_q[c][DEPTH-2:0], sync2_q[c]};
            end
        end

        case (state_q)
            ST_FILL: begin
                // A trigger edge in the cycle that completes the fill is
                // rejected. ARMED starts on the next cycle.
                trig_reject = trig_edge;
                cnt_d       = cnt_q + CNT_ONE;
                if (cnt_q == FILL_LAST) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (trig_edge) begin
                    cnt_d   = POST_LEN;
                    state_d = ST_POST;
`ifdef SAMPLER_TIMESTAMP_EN
                    trig_ts_d = ts_q;
`endif
                end
            end

            ST_POST: begin
                trig_reject = trig_edge;
                cnt_d       = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d       = ST_HOLD;
                    event_ready_d = 1'b1;
                end
            end

            ST_HOLD: begin
                // When the release and a trigger edge fall in the same cycle,
                // the release wins and the edge is counted as missed.
                trig_reject = trig_edge;
                if (event_saved) begin
                    state_d       = ST_FILL;
                    cnt_d         = '0;
                    event_ready_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_FILL;
                cnt_d   = '0;
            end
        endcase

        if (trig_reject && (missed_q != 16'hFFFF)) begin
            missed_d = missed_q + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_FILL;
            cnt_q         <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            trig_prev_q   <= 1'b0;
            // NOTE: evento is built from flip-flops, not RAM, and its reset
            // value is visible on the port. Every bit is cleared here, so no
            // block RAM can be inferred for it.
            evento_q      <= '0;
            event_ready_q <= 1'b0;
            missed_q      <= '0;
`ifdef SAMPLER_TIMESTAMP_EN
            ts_q          <= '0;
            trig_ts_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments only. Each flop then samples the
            // value its _d net had before this edge, whatever the statement
            // order.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            trig_prev_q   <= trig_prev_d;
            evento_q      <= evento_d;
            event_ready_q <= event_ready_d;
            missed_q      <= missed_d;
`ifdef SAMPLER_TIMESTAMP_EN
            ts_q          <= ts_d;
            trig_ts_q     <= trig_ts_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign evento      = evento_q;
    assign event_ready = event_ready_q;
    assign missed_trig = missed_q;

`ifdef SAMPLER_TIMESTAMP_EN
    assign trig_ts = trig_ts_q;
`else
    assign trig_ts = '0;
`endif

endmodule

// File: tb/tb_sampler_ring.sv
// -----------------------------------------------------------------------------
// tb_sampler_ring
//
// Self-checking bench for sampler_ring with the default parameters.
//
// The reference model is written as a timeline, not as a state machine:
//   - it records when triggers may next be accepted, as an edge number;
//   - it records when an accepted trigger becomes a held event;
//   - it keeps a log of the synchronised samples as a shifting window.
//
// Edges are numbered from reset release: edge 1 is the first rising clock
// edge after aresetn goes high. Inputs change on the falling edge. Outputs
// are sampled on the falling edge, half a cycle after the rising edge they
// follow.
// -----------------------------------------------------------------------------
module tb_sampler_ring;

    localparam int N_CH      = 16;
    localparam int DEPTH     = 64;
    localparam int POST_TRIG = 32;
    localparam int TS_W      = 32;

    typedef logic [N_CH-1:0][DEPTH-1:0] win_t;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [N_CH-1:0]   ch_p;
    logic [N_CH-1:0]   ch_n;
    logic              trig;
    logic              saved;
    win_t              evento;
    logic              event_ready;
    logic [15:0]       missed_trig;
    logic [TS_W-1:0]   trig_ts;

    int checks = 0;
    int errors = 0;

    sampler_ring #(
        .N_CH      (N_CH),
        .DEPTH     (DEPTH),
        .POST_TRIG (POST_TRIG),
        .TS_W      (TS_W)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .Ch_A_P      (ch_p),
        .Ch_A_N      (ch_n),
        .trig_tresh  (trig),
        .event_saved (saved),
        .evento      (evento),
        .event_ready (event_ready),
        .missed_trig (missed_trig),
        .trig_ts     (trig_ts)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    int                edge_n;
    logic [N_CH-1:0]   pin_log[$];     // differential value seen at each edge
    win_t              m_win;
    bit                m_hold;
    int                m_missed;
    logic [TS_W-1:0]   m_ts;
    bit                m_prev;
    int                m_arm_at;       // first edge at which a trigger is accepted
    int                m_trig_at;      // edge of the accepted trigger, -1 if none

    task automatic model_reset();
        edge_n    = 0;
        pin_log.delete();
        m_win     = '0;
        m_hold    = 1'b0;
        m_missed  = 0;
        m_ts      = '0;
        m_prev    = 1'b0;
        m_arm_at  = DEPTH - POST_TRIG + 1;
        m_trig_at = -1;
    endtask

    task automatic model_miss();
        if (m_missed < 65535) m_missed++;
    endtask

    task automatic model_edge(input logic [N_CH-1:0] pin, input logic t, input logic sv);
        logic [N_CH-1:0] s;
        bit              rise;
        edge_n++;
        // The value reaching the window is the pin value from two edges earlier.
        s = (pin_log.size() >= 2) ? pin_log[pin_log.size()-2] : '0;
        pin_log.push_back(pin);
        if (pin_log.size() > 4) void'(pin_log.pop_front());
        rise   = t && !m_prev;
        m_prev = t;

        if (m_hold) begin
            if (rise) model_miss();
            if (sv) begin
                m_hold   = 1'b0;
                // Shifts resume at the next edge. The edge that completes the
                // fill is still rejected.
                m_arm_at = edge_n + (DEPTH - POST_TRIG) + 1;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) m_win[c] = {m_win[c][DEPTH-2:0], s[c]};
            if (m_trig_at >= 0) begin
                if (rise) model_miss();
                if (edge_n == m_trig_at + POST_TRIG) begin
                    m_hold    = 1'b1;
                    m_trig_at = -1;
                end
            end else if (edge_n >= m_arm_at) begin
                if (rise) begin
                    m_trig_at = edge_n;
`ifdef SAMPLER_TIMESTAMP_EN
                    m_ts = TS_W'(edge_n - 1);
`endif
                end
            end else if (rise) begin
                model_miss();
            end
        end
    endtask

    // Applies the current inputs at the next rising edge, then returns on the
    // falling edge that follows.
    task automatic tick();
        @(posedge clk);
        model_edge(ch_p & ~ch_n, trig, saved);
        @(negedge clk);
    endtask

    task automatic set_pins(input logic [N_CH-1:0] v);
        ch_p = v;
        ch_n = ~v;
    endtask

    function automatic int first_diff_ch(input win_t a, input win_t b);
        for (int c = 0; c < N_CH; c++) if (a[c] !== b[c]) return c;
        return 0;
    endfunction

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        int c;
        aresetn = 1'b0;
        set_pins('0);
        trig  = 1'b0;
        saved = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({event_ready, missed_trig, trig_ts} !== '0) begin
            errors++;
            $display("FAIL reset_status: got ready=%b missed=%h ts=%h, expected all zero",
                     event_ready, missed_trig, trig_ts);
        end
        checks++;
        if (evento !== '0) begin
            errors++;
            c = first_diff_ch(evento, '0);
            $display("FAIL reset_evento ch %0d: got %h expected 0", c, evento[c]);
        end
        aresetn = 1'b1;
        for (int i = 1; i < 10; i++) tick();
        trig = 1'b1;
        tick();                          // edge 10: trigger edge while in FILL
        trig = 1'b0;
        repeat (2) tick();
        checks++;
        if (missed_trig !== 16'd1 || 16'(m_missed) !== 16'd1) begin
            errors++;
            $display("FAIL fill_missed: got %0d expected 1 (model %0d)", missed_trig, m_missed);
        end
        checks++;
        if (event_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready: got %b expected 0", event_ready);
        end
        checks++;
        if (evento !== '0) begin
            errors++;
            c = first_diff_ch(evento, '0);
            $display("FAIL fill_evento ch %0d: got %h expected 0", c, evento[c]);
        end
    endtask

    task automatic test_capture();
        win_t exp_win;
        int   t;
        int   c;
        t = (m_arm_at > edge_n + 3) ? m_arm_at : edge_n + 3;
        while (edge_n < t - 3) tick();
        set_pins(16'h0001);
        tick();                          // edge t-2: pulse on channel 0
        set_pins('0);
        tick();                          // edge t-1
        trig = 1'b1;
        tick();                          // edge t: accepted trigger
        trig = 1'b0;
        for (int i = 1; i < POST_TRIG; i++) tick();
        checks++;
        if (event_ready !== 1'b0) begin
            errors++;
            $display("FAIL capture_ready_early: got %b expected 0 at T+%0d", event_ready, POST_TRIG - 1);
        end
        tick();
        checks++;
        if (event_ready !== 1'b1) begin
            errors++;
            $display("FAIL capture_ready: got %b expected 1 at T+%0d", event_ready, POST_TRIG);
        end
        exp_win    = '0;
        exp_win[0] = 64'h0000_0001_0000_0000;
        checks++;
        if (evento !== exp_win) begin
            errors++;
            c = first_diff_ch(evento, exp_win);
            $display("FAIL capture_evento ch %0d: got %h expected %h", c, evento[c], exp_win[c]);
        end
        checks++;
        if (evento !== m_win) begin
            errors++;
            c = first_diff_ch(evento, m_win);
            $display("FAIL capture_model ch %0d: got %h expected %h", c, evento[c], m_win[c]);
        end
    endtask

    task automatic test_hold_triggers();
        win_t snap;
        int   exp_missed;
        int   c;
        snap       = m_win;
        exp_missed = m_missed + 2;
        set_pins(16'hA5C3);              // the window must ignore this while held
        repeat (2) begin
            trig = 1'b1;
            tick();
            trig = 1'b0;
            tick();
        end
        set_pins('0);
        checks++;
        if (missed_trig !== 16'(exp_missed)) begin
            errors++;
            $display("FAIL hold_missed: got %0d expected %0d", missed_trig, exp_missed);
        end
        checks++;
        if (evento !== snap) begin
            errors++;
            c = first_diff_ch(evento, snap);
            $display("FAIL hold_evento ch %0d: got %h expected %h", c, evento[c], snap[c]);
        end
        checks++;
        if (event_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_ready: got %b expected 1", event_ready);
        end
    endtask

    task automatic test_release_rearm();
        int r;
        int base;
        // First run: the edge coincides with the last fill shift and is rejected.
        base  = m_missed;
        saved = 1'b1;
        tick();                          // edge R: release
        saved = 1'b0;
        r = edge_n;
        checks++;
        if (event_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_ready: got %b expected 0 after R", event_ready);
        end
        while (edge_n < r + 31) tick();
        trig = 1'b1;
        tick();                          // edge R+32: completes the fill
        trig = 1'b0;
        checks++;
        if (missed_trig !== 16'(base + 1)) begin
            errors++;
            $display("FAIL rearm_early_missed: got %0d expected %0d", missed_trig, base + 1);
        end
        tick();
        trig = 1'b1;
        tick();                          // armed now: accepted
        trig = 1'b0;
        checks++;
        if (missed_trig !== 16'(base + 1)) begin
            errors++;
            $display("FAIL rearm_accept_missed: got %0d expected %0d", missed_trig, base + 1);
        end
        for (int i = 0; i < POST_TRIG; i++) tick();
        checks++;
        if (event_ready !== 1'b1) begin
            errors++;
            $display("FAIL rearm_first_event: got %b expected 1", event_ready);
        end
        // Second run: the first edge after the fill completes is accepted.
        base  = m_missed;
        saved = 1'b1;
        tick();
        saved = 1'b0;
        r = edge_n;
        while (edge_n < r + 32) tick();
        trig = 1'b1;
        tick();                          // edge R+33
        trig = 1'b0;
        checks++;
        if (missed_trig !== 16'(base)) begin
            errors++;
            $display("FAIL rearm_boundary_missed: got %0d expected %0d", missed_trig, base);
        end
        for (int i = 1; i < POST_TRIG; i++) tick();
        checks++;
        if (event_ready !== 1'b0) begin
            errors++;
            $display("FAIL rearm_boundary_early: got %b expected 0", event_ready);
        end
        tick();
        checks++;
        if (event_ready !== 1'b1) begin
            errors++;
            $display("FAIL rearm_boundary_ready: got %b expected 1", event_ready);
        end
    endtask

    task automatic test_held_trigger();
        int  r;
        int  base;
        int  events;
        bit  prev_ready;
        base  = m_missed;
        saved = 1'b1;
        tick();
        saved = 1'b0;
        r = edge_n;
        while (edge_n < r + 32) tick();
        trig       = 1'b1;               // rises while ARMED, then stays high
        events     = 0;
        prev_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            saved = (i == 60);           // release the event while trig is still high
            tick();
            if (event_ready && !prev_ready) events++;
            prev_ready = event_ready;
        end
        saved = 1'b0;
        trig  = 1'b0;
        tick();
        checks++;
        if (events !== 1) begin
            errors++;
            $display("FAIL held_trig_events: got %0d expected 1", events);
        end
        checks++;
        if (missed_trig !== 16'(base) || event_ready !== 1'b0) begin
            errors++;
            $display("FAIL held_trig_status: got missed=%0d ready=%b expected missed=%0d ready=0",
                     missed_trig, event_ready, base);
        end
    endtask

    task automatic test_random();
        int c;
        for (int i = 0; i < 3000; i++) begin
            set_pins(16'($urandom));
            trig  = ($urandom_range(0, 3) == 0);
            saved = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if ({event_ready, missed_trig, trig_ts} !== {m_hold, 16'(m_missed), m_ts}) begin
                errors++;
                $display("FAIL random_status edge %0d: got ready=%b missed=%0d ts=%h expected ready=%b missed=%0d ts=%h",
                         edge_n, event_ready, missed_trig, trig_ts, m_hold, m_missed, m_ts);
            end
            checks++;
            if (evento !== m_win) begin
                errors++;
                c = first_diff_ch(evento, m_win);
                $display("FAIL random_evento edge %0d ch %0d: got %h expected %h",
                         edge_n, c, evento[c], m_win[c]);
            end
        end
        trig  = 1'b0;
        saved = 1'b0;
        set_pins('0);
    endtask

    task automatic test_timestamp();
        logic [TS_W-1:0] exp_ts;
        #2 aresetn = 1'b0;
        model_reset();
        trig  = 1'b0;
        saved = 1'b0;
        set_pins('0);
        @(negedge clk);
        aresetn = 1'b1;
        while (edge_n < 499) tick();
        trig = 1'b1;
        tick();                          // edge 500
        trig = 1'b0;
        tick();
`ifdef SAMPLER_TIMESTAMP_EN
        exp_ts = 499;
`else
        exp_ts = 0;
`endif
        checks++;
        if (trig_ts !== exp_ts || m_ts !== exp_ts) begin
            errors++;
            $display("FAIL timestamp: got %0d expected %0d (model %0d)", trig_ts, exp_ts, m_ts);
        end
    endtask

    task automatic test_reset_mid_post();
        int c;
        // The timestamp trigger leaves the design in POST.
        for (int i = 0; i < 10; i++) begin
            set_pins(16'($urandom));
            trig = (i == 3);
            tick();
        end
        trig = 1'b0;
        checks++;
        if (missed_trig !== 16'(m_missed) || event_ready !== 1'b0 || evento !== m_win) begin
            errors++;
            $display("FAIL pre_reset_post: got missed=%0d ready=%b expected missed=%0d ready=0",
                     missed_trig, event_ready, m_missed);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({event_ready, missed_trig, trig_ts} !== '0) begin
            errors++;
            $display("FAIL midpost_reset_status: got ready=%b missed=%0d ts=%h expected all zero",
                     event_ready, missed_trig, trig_ts);
        end
        checks++;
        if (evento !== '0) begin
            errors++;
            c = first_diff_ch(evento, '0);
            $display("FAIL midpost_reset_evento ch %0d: got %h expected 0", c, evento[c]);
        end
        model_reset();
        set_pins('0);
        @(negedge clk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        trig = 1'b1;
        tick();                          // edge 5: must be rejected, back in FILL
        trig = 1'b0;
        checks++;
        if (missed_trig !== 16'd1) begin
            errors++;
            $display("FAIL midpost_refill_missed: got %0d expected 1", missed_trig);
        end
        for (int i = 0; i < 40; i++) begin
            set_pins(16'($urandom));
            trig = (i == 35);
            tick();
        end
        trig = 1'b0;
        for (int i = 0; i < POST_TRIG; i++) tick();
        checks++;
        if (event_ready !== 1'b1 || m_hold !== 1'b1) begin
            errors++;
            $display("FAIL midpost_recapture_ready: got %b expected 1", event_ready);
        end
        checks++;
        if (evento !== m_win) begin
            errors++;
            c = first_diff_ch(evento, m_win);
            $display("FAIL midpost_recapture_evento ch %0d: got %h expected %h", c, evento[c], m_win[c]);
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequence
    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_capture();
        test_hold_triggers();
        test_release_rearm();
        test_held_trigger();
        test_random();
        test_timestamp();
        test_reset_mid_post();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
